// File: rtl/fir_sample_fifo.sv
// rtl/fir_sample_fifo.sv - strobe-qualified sample FIFO feeding the FIR input stream
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   in_data              raw sample from pins (held stable around each strobe)
//   in_strobe            asynchronous strobe; each rising edge enqueues in_data
//   ovf_clr              clears the sticky overflow flag
//   m_axis_fir_tdata     head-of-FIFO sample, forced to 0 when empty
//   m_axis_fir_tvalid    FIFO non-empty
//   m_axis_fir_tready    FIR accepts the head sample
//   overflow             sticky; a strobe edge was dropped on a full FIFO
//   level                current occupancy, 0..DEPTH

module fir_sample_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_strobe,
  input  logic                       ovf_clr,
  output logic [DATA_W-1:0]          m_axis_fir_tdata,
  output logic                       m_axis_fir_tvalid,
  input  logic                       m_axis_fir_tready,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic              s1, s2, s3;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic push, pop, full, do_write, drop;

  // s1 is the metastability-absorbing stage; edge detect uses the settled s2/s3.
  // Resetting them high means a strobe held high across reset must first go low.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= in_strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push     = s2 & ~s3;
  assign pop      = m_axis_fir_tvalid & m_axis_fir_tready;
  assign full     = (level == LW'(DEPTH));
  // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // A new drop takes priority over a clear in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign m_axis_fir_tvalid = (level != '0);
  assign m_axis_fir_tdata  = m_axis_fir_tvalid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_sample_fifo.sv
// tb/tb_fir_sample_fifo.sv - self-checking bench for fir_sample_fifo

module tb_fir_sample_fifo;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_strobe;
  logic              ovf_clr;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              overflow;
  logic [2:0]        level;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of held samples, sticky flag, and a list of strobe
  // rises still travelling toward their push edge (edges remaining).
  logic [DATA_W-1:0] q[$];
  int                pend[$];
  bit                ovf_m;
  bit                last_s;

  fir_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_strobe         (in_strobe),
    .ovf_clr           (ovf_clr),
    .m_axis_fir_tdata  (tdata),
    .m_axis_fir_tvalid (tvalid),
    .m_axis_fir_tready (tready),
    .overflow          (overflow),
    .level             (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [DATA_W-1:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : '0;
    chk("level", 32'(level), 32'(q.size()));
    chk("tvalid", 32'(tvalid), 32'(q.size() != 0));
    chk("tdata", 32'(tdata), 32'(exp_data));
    chk("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  // Advance the model across one rising edge using the inputs currently driven,
  // then let the edge happen and compare 1 time unit later.
  task automatic tick();
    bit push_m, pop_m, drop_m;
    if (reset) begin
      q.delete();
      pend.delete();
      ovf_m  = 1'b0;
      last_s = 1'b1;
    end else begin
      push_m = 1'b0;
      foreach (pend[i]) begin
        pend[i]--;
        if (pend[i] == 0) push_m = 1'b1;
      end
      while (pend.size() != 0 && pend[0] <= 0) void'(pend.pop_front());
      // A rise first seen at edge k is pushed at edge k+2.
      if (in_strobe && !last_s) pend.push_back(2);
      last_s = in_strobe;
      pop_m  = (q.size() != 0) && tready;
      drop_m = push_m && (q.size() == DEPTH) && !pop_m;
      if (pop_m) void'(q.pop_front());
      if (push_m && !drop_m) q.push_back(in_data);
      if (drop_m) ovf_m = 1'b1;
      else if (ovf_clr) ovf_m = 1'b0;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [DATA_W-1:0] d);
    in_data   = d;
    in_strobe = 1'b1;
    ticks(2);
    in_strobe = 1'b0;
    ticks(2);
  endtask

  task automatic drain();
    tready = 1'b1;
    ticks(DEPTH + 1);
    tready = 1'b0;
  endtask

  initial begin
    int hold;
    reset     = 1'b1;
    in_data   = '0;
    in_strobe = 1'b1;
    ovf_clr   = 1'b0;
    tready    = 1'b0;

    // Strobe held high across reset release must not push.
    ticks(3);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_tvalid", 32'(tvalid), 32'd0);
    chk("reset_tdata", 32'(tdata), 32'd0);
    reset = 1'b0;
    ticks(10);
    chk("held_strobe_level", 32'(level), 32'd0);
    in_strobe = 1'b0;
    ticks(3);
    pulse(6'h15);
    ticks(1);
    chk("one_entry_level", 32'(level), 32'd1);
    chk("one_entry_tdata", 32'(tdata), 32'h15);
    drain();

    // Single sample latency: rise first seen at edge k.
    in_data   = 6'h2A;
    in_strobe = 1'b1;
    tick();                     // edge k
    tick();                     // edge k+1
    chk("latency_early_tvalid", 32'(tvalid), 32'd0);
    in_strobe = 1'b0;
    tick();                     // edge k+2
    tick();                     // edge k+3
    chk("latency_tvalid", 32'(tvalid), 32'd1);
    chk("latency_tdata", 32'(tdata), 32'h2A);
    chk("latency_level", 32'(level), 32'd1);
    tready = 1'b1;
    tick();
    chk("single_pop_tvalid", 32'(tvalid), 32'd0);
    tready = 1'b0;

    // Ordering across pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int v = 1; v <= 4; v++) pulse(DATA_W'(v));
      tick();
      chk("fill_level", 32'(level), 32'd4);
      drain();
    end
    chk("wrap_overflow", 32'(overflow), 32'd0);

    // Overflow: fifth sample is lost.
    for (int v = 'h10; v <= 'h14; v++) pulse(DATA_W'(v));
    tick();
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(tdata), 32'h10);
    drain();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Push and pop together on a full FIFO.
    for (int v = 5; v <= 8; v++) pulse(DATA_W'(v));
    in_data   = 6'h09;
    in_strobe = 1'b1;
    ticks(2);
    in_strobe = 1'b0;
    tready    = 1'b1;
    tick();                     // push edge with pop
    tready    = 1'b0;
    tick();
    chk("fullpp_level", 32'(level), 32'd4);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    chk("fullpp_head", 32'(tdata), 32'h06);
    drain();

    // Reset mid-stream.
    for (int v = 'h21; v <= 'h23; v++) pulse(DATA_W'(v));
    chk("pre_reset_level", 32'(level), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_tvalid", 32'(tvalid), 32'd0);
    chk("mid_reset_tdata", 32'(tdata), 32'd0);
    chk("mid_reset_level", 32'(level), 32'd0);
    ticks(2);
    pulse(6'h3F);
    tick();
    chk("post_reset_level", 32'(level), 32'd1);
    chk("post_reset_tdata", 32'(tdata), 32'h3F);
    drain();

    // Randomized traffic respecting 2-cycle minimum strobe high/low times.
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold >= 2 && ($urandom_range(0, 2) == 0)) begin
        if (!in_strobe) in_data = DATA_W'($urandom);
        in_strobe = ~in_strobe;
        hold = 0;
      end
      tready  = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      hold++;
    end
    in_strobe = 1'b0;
    ovf_clr   = 1'b0;
    ticks(4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
